uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO, replacing the fixed 8N1 receive path on the NES board link. It oversamples the asynchronous `rx_in` pin against `clk_in` and decodes frames with configurable data width and parity. Good bytes are pushed into a first-word-fall-through FIFO. Frame, parity and overrun faults are reported as sticky flags for the host-command logic that sits behind it.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `clk_in` cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, range 5–8, sent LSB first.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, default 16: receive FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk_in` in 1: system clock.
- `nreset` in 1: reset, asynchronous and active-low.
- `rx_in` in 1: asynchronous serial input; idles high.
- `rd_en` in 1: pop request for the FIFO head.
- `clr_err` in 1: clears all sticky error flags.
- `rd_data` out DATA_BITS: FIFO head; valid while `empty` = 0.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds FIFO_DEPTH entries.
- `count` out clog2(FIFO_DEPTH)+1: number of stored entries.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `parity_err` out 1: sticky; a parity mismatch occurred.
- `overrun` out 1: sticky; a good byte arrived while the FIFO was full.

## Operation
Input synchroniser:
- `rx_in` passes through a 2-flop synchroniser, reset to 1. All decoding uses the synchronised value `rxs`.

Receive FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- **IDLE**: a 1→0 transition on `rxs` clears the bit timer and enters START.
- **START**: at timer = CLKS_PER_BIT/2 − 1 (the mid-start sample), sample `rxs`.
  - `rxs` = 1: false start, return to IDLE. No flag is set.
  - `rxs` = 0: clear the timer and enter DATA.
- **DATA**: each time the timer reaches CLKS_PER_BIT − 1, shift `rxs` in LSB-first and clear the timer. After DATA_BITS samples, enter PAR if PARITY ≠ 0, otherwise STOP.
- **PAR**: sample at CLKS_PER_BIT − 1.
  - Odd parity: XOR of data bits and parity bit must be 1.
  - Even parity: that XOR must be 0.
  - The result is latched, then the FSM enters STOP.
- **STOP**: sample at CLKS_PER_BIT − 1.
  - `rxs` = 1 and parity OK: push the byte if not full, or if full with `rd_en` asserted in the same cycle. Otherwise set `overrun` and drop the byte. Return to IDLE.
  - `rxs` = 1 and parity bad: set `parity_err`, drop the byte, return to IDLE.
  - `rxs` = 0: set `frame_err`, drop the byte, enter WAIT_HIGH. A break or framing fault never raises `parity_err`.
- **WAIT_HIGH**: stay until `rxs` = 1, then go to IDLE. A held-low line or break never produces spurious frames.

FIFO:
- First-word-fall-through. `rd_data` always shows the head entry.
- `rd_en` while `empty`: ignored; pointers and `count` unchanged.
- Push and pop in the same cycle: both occur and `count` is unchanged. This also applies when full.
- Pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Error flags:
- `clr_err` clears all three sticky flags on the next edge.
- If a set event and `clr_err` occur in the same cycle, the set wins.

## Timing
- Reset (async assert, sync release) values:
  - `empty` = 1, `full` = 0, `count` = 0, `rd_data` = 0.
  - All error flags = 0; FSM in IDLE; synchroniser flops = 1.
- Frame latency: `empty` falls and `count` increments on the edge after the stop-bit sample.
  - The stop-bit sample falls at 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)·CLKS_PER_BIT cycles after the `rx_in` falling edge, where P = 1 if PARITY ≠ 0, else 0.
  - Tolerance: ±1 cycle of synchroniser phase.
- Pop: `rd_en` sampled high with `empty` = 0 advances the head. The new `rd_data`, `count` and `empty` are visible on the next edge.
- The FSM returns to IDLE at the mid-stop sample, so back-to-back frames with zero idle time are received.
- Reset asserted mid-frame aborts the frame immediately and flushes the FIFO. After release, the FSM waits in IDLE for a new falling edge. A low line at release is treated as a start edge only after `rxs` has first been seen high.

## Test plan
- 8N1 defaults: frame start, bit0 = 1, bits1–7 = 0, stop → `rd_data` = 0x01, `count` = 1, `empty` falls 2 + 434 + 9·868 ±1 cycles after the start edge. Then a frame of start + 8 zeros + stop → second entry 0x00, `count` = 2. No flags.
- PARITY = 2: send 0xA5 with parity bit 0 → accepted. Send 0xA5 with parity bit 1 → `parity_err` = 1, `count` unchanged. `clr_err` pulse → flag clears.
- Break: hold `rx_in` low for 20 bit times → exactly one `frame_err`, no FIFO push. After the line returns high, a 0x3C frame is received correctly.
- Overrun: FIFO_DEPTH = 4, send 5 frames 0x10–0x14 without reads → `full` = 1, `overrun` = 1. Pops return 0x10, 0x11, 0x12, 0x13, then `empty` = 1.
- Glitch: `rx_in` low for 100 cycles (below half a bit) → no push and no flags; FSM back in IDLE.
- Reset mid-frame: assert `nreset` during bit 3 of 0x55 → all outputs at reset values. The next full 0x55 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the serial input, the FIFO read port and the
// sticky error flags of uart_rx_fifo.
//   rx_in      serial input, idles high
//   rd_en      pop request for the FIFO head
//   clr_err    clears the three sticky error flags
//   rd_data    FIFO head (first-word-fall-through), valid while empty = 0
//   empty      FIFO holds no entries
//   full       FIFO holds FIFO_DEPTH entries
//   count      number of stored entries
//   frame_err  sticky, a stop bit was sampled low
//   parity_err sticky, a parity mismatch occurred
//   overrun    sticky, a good byte arrived while the FIFO was full
// master = host side, slave = receiver.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                         rx_in;
  logic                         rd_en;
  logic                         clr_err;
  logic [DATA_BITS-1:0]         rd_data;
  logic                         empty;
  logic                         full;
  logic [$clog2(FIFO_DEPTH):0]  count;
  logic                         frame_err;
  logic                         parity_err;
  logic                         overrun;

  modport master (
    output rx_in, rd_en, clr_err,
    input  rd_data, empty, full, count, frame_err, parity_err, overrun
  );

  modport slave (
    input  rx_in, rd_en, clr_err,
    output rd_data, empty, full, count, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (DATA_BITS data, optional
// parity, one stop bit) feeding a first-word-fall-through receive FIFO.
// Ports:
//   clk_in   system clock
//   nreset   asynchronous active-low reset
//   bus      uart_rx_fifo_if.slave (rx_in, rd_en, clr_err in;
//            rd_data, empty, full, count, frame_err, parity_err, overrun out)
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | line idle, waiting for a 1->0 edge on rxs
// S_START   | timing to the middle of the start bit
// S_DATA    | sampling data bits at mid-bit, LSB first
// S_PAR     | sampling the parity bit
// S_STOP    | sampling the stop bit, push or flag the frame
// S_WAIT_HIGH | stop bit was low (break/frame fault), wait for line high
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input logic           clk_in,
  input logic           nreset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_BIT    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  logic       sync1, rxs, rxs_prev;
  logic [1:0] sync_vld;

  // rxs_prev only carries real line samples: it stays 0 until the
  // synchroniser has been refilled after reset, so a line that is low at
  // release is not mistaken for a start edge until it has been seen high.
  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      sync_vld <= 2'b00;
      rxs_prev <= 1'b0;
    end else begin
      sync1    <= bus.rx_in;
      rxs      <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      rxs_prev <= sync_vld[1] & rxs;
    end
  end

  state_t               state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_ok;
  logic                 tick, stop_tick;

  assign tick      = (timer == '0);
  assign stop_tick = (state == S_STOP) && tick;

  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (rxs_prev && !rxs) begin
            state <= S_START;
            timer <= T_HALF;
          end
        end
        S_START: begin
          if (!tick) begin
            timer <= timer - TW'(1);
          end else if (rxs) begin
            state <= S_IDLE;
          end else begin
            state   <= S_DATA;
            timer   <= T_BIT;
            bit_cnt <= '0;
            par_ok  <= 1'b1;
          end
        end
        S_DATA: begin
          if (!tick) begin
            timer <= timer - TW'(1);
          end else begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            timer <= T_BIT;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        S_PAR: begin
          if (!tick) begin
            timer <= timer - TW'(1);
          end else begin
            par_ok <= (PARITY == 1) ? (^shreg ^ rxs) : ~(^shreg ^ rxs);
            timer  <= T_BIT;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (!tick) begin
            timer <= timer - TW'(1);
          end else begin
            state <= rxs ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 is_empty, is_full, pop, push_req, push;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == DEPTH_C);
  assign pop      = bus.rd_en && !is_empty;
  assign push_req = stop_tick && rxs && par_ok;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign push     = push_req && (!is_full || pop);

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  logic frame_err, parity_err, overrun;

  // Set terms are OR-ed after the clear so a simultaneous event wins.
  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (stop_tick && !rxs)          || (frame_err  && !bus.clr_err);
      parity_err <= (stop_tick && rxs && !par_ok) || (parity_err && !bus.clr_err);
      overrun    <= (push_req && is_full && !pop) || (overrun    && !bus.clr_err);
    end
  end

  assign bus.rd_data    = is_empty ? '0 : mem[rd_ptr];
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = cnt;
  assign bus.frame_err  = frame_err;
  assign bus.parity_err = parity_err;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CA = 868;
  localparam int CB = 16;
  localparam int HB = CB / 2;
  // Nominal start-edge to push latency for the 8N1 instance.
  localparam int NOM_A = 2 + CA / 2 + 9 * CA;
  // Edge (counted from the negedge that drives the start bit) on which the
  // parity instance pushes: nominal latency plus the first half cycle.
  localparam int PUSH_EDGE_B = 3 + HB + 10 * CB;

  logic clk, nreset_a, nreset_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  bus_b ();

  uart_rx_fifo #(.CLKS_PER_BIT(CA), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) dut_a (
    .clk_in(clk), .nreset(nreset_a), .bus(bus_a));
  uart_rx_fifo #(.CLKS_PER_BIT(CB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk_in(clk), .nreset(nreset_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) bus_b.rx_in = v;
    else     bus_a.rx_in = v;
  endtask

  task automatic hold_line(input bit sel, input logic v, input int n);
    set_line(sel, v);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit flip, input logic stop_v);
    int   c;
    logic p;
    c = sel ? CB : CA;
    hold_line(sel, 1'b0, c);
    for (int i = 0; i < 8; i++) hold_line(sel, d[i], c);
    if (sel) begin
      p = (^d) ^ flip;
      hold_line(sel, p, c);
    end
    hold_line(sel, stop_v, c);
  endtask

  task automatic pop(input bit sel);
    if (sel) bus_b.rd_en = 1'b1;
    else     bus_a.rd_en = 1'b1;
    @(negedge clk);
    bus_a.rd_en = 1'b0;
    bus_b.rd_en = 1'b0;
  endtask

  task automatic clr_b();
    bus_b.clr_err = 1'b1;
    @(negedge clk);
    bus_b.clr_err = 1'b0;
  endtask

  task automatic drain_b();
    for (int i = 0; i < 8; i++) if (!bus_b.empty) pop(1'b1);
  endtask

  task automatic chk_reset_vals(input bit sel);
    if (sel) begin
      chk("rst_b_empty", int'(bus_b.empty), 1);
      chk("rst_b_full", int'(bus_b.full), 0);
      chk("rst_b_count", int'(bus_b.count), 0);
      chk("rst_b_rd_data", int'(bus_b.rd_data), 0);
      chk("rst_b_frame_err", int'(bus_b.frame_err), 0);
      chk("rst_b_parity_err", int'(bus_b.parity_err), 0);
      chk("rst_b_overrun", int'(bus_b.overrun), 0);
    end else begin
      chk("rst_a_empty", int'(bus_a.empty), 1);
      chk("rst_a_full", int'(bus_a.full), 0);
      chk("rst_a_count", int'(bus_a.count), 0);
      chk("rst_a_rd_data", int'(bus_a.rd_data), 0);
      chk("rst_a_frame_err", int'(bus_a.frame_err), 0);
      chk("rst_a_parity_err", int'(bus_a.parity_err), 0);
      chk("rst_a_overrun", int'(bus_a.overrun), 0);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         flip;
    logic       stop_v;
    int         exp_cnt;
    int         exp_head;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] q [$];
  int         k;
  int         e_perr, e_ferr, e_ovr;
  int         f, npop;
  logic [7:0] b;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1, 'hA5, 0, 0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 0, 0,    1, 0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 0, 0,    0, 1};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 1, 'hFF, 0, 0};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 1, 'h00, 0, 0};
    tbl[5] = '{8'h5A, 1'b1, 1'b1, 0, 0,    1, 0};
    tbl[6] = '{8'h81, 1'b1, 1'b0, 0, 0,    0, 1};
    tbl[7] = '{8'h7E, 1'b0, 1'b1, 1, 'h7E, 0, 0};

    bus_a.rx_in = 1'b1; bus_a.rd_en = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.rx_in = 1'b1; bus_b.rd_en = 1'b0; bus_b.clr_err = 1'b0;
    nreset_a = 1'b0;
    nreset_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals(1'b0);
    chk_reset_vals(1'b1);
    nreset_a = 1'b1;
    nreset_b = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 latency and basic reception
    k = 0;
    fork
      send_frame(1'b0, 8'h01, 1'b0, 1'b1);
      begin
        while (bus_a.empty && k < 20000) begin
          @(negedge clk);
          k++;
        end
      end
    join
    chk("a_latency_in_window", int'(k >= NOM_A - 1 && k <= NOM_A + 1), 1);
    chk("a_first_rd_data", int'(bus_a.rd_data), 'h01);
    chk("a_first_count", int'(bus_a.count), 1);
    send_frame(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a_second_count", int'(bus_a.count), 2);
    chk("a_head_kept", int'(bus_a.rd_data), 'h01);
    chk("a_no_flags", int'({bus_a.frame_err, bus_a.parity_err, bus_a.overrun}), 0);
    pop(1'b0);
    chk("a_pop1_rd_data", int'(bus_a.rd_data), 'h00);
    chk("a_pop1_count", int'(bus_a.count), 1);
    pop(1'b0);
    chk("a_pop2_empty", int'(bus_a.empty), 1);
    pop(1'b0);
    chk("a_pop_empty_count", int'(bus_a.count), 0);

    // glitch shorter than half a bit
    hold_line(1'b0, 1'b0, 100);
    hold_line(1'b0, 1'b1, 1000);
    chk("glitch_count", int'(bus_a.count), 0);
    chk("glitch_flags", int'({bus_a.frame_err, bus_a.parity_err, bus_a.overrun}), 0);
    send_frame(1'b0, 8'hA7, 1'b0, 1'b1);
    chk("after_glitch_count", int'(bus_a.count), 1);
    chk("after_glitch_data", int'(bus_a.rd_data), 'hA7);
    pop(1'b0);

    // table-driven frames on the even-parity instance
    for (int i = 0; i < 8; i++) begin
      send_frame(1'b1, tbl[i].d, tbl[i].flip, tbl[i].stop_v);
      hold_line(1'b1, 1'b1, 2 * CB);
      chk("tbl_count", int'(bus_b.count), tbl[i].exp_cnt);
      if (tbl[i].exp_cnt > 0) chk("tbl_head", int'(bus_b.rd_data), tbl[i].exp_head);
      chk("tbl_parity_err", int'(bus_b.parity_err), tbl[i].exp_perr);
      chk("tbl_frame_err", int'(bus_b.frame_err), tbl[i].exp_ferr);
      chk("tbl_overrun", int'(bus_b.overrun), 0);
      drain_b();
      clr_b();
      chk("tbl_clr_flags", int'({bus_b.frame_err, bus_b.parity_err}), 0);
      chk("tbl_drained", int'(bus_b.count), 0);
    end

    // break: 20 bit times low
    hold_line(1'b1, 1'b0, 20 * CB);
    hold_line(1'b1, 1'b1, 2 * CB);
    chk("break_frame_err", int'(bus_b.frame_err), 1);
    chk("break_parity_err", int'(bus_b.parity_err), 0);
    chk("break_count", int'(bus_b.count), 0);
    clr_b();
    send_frame(1'b1, 8'h3C, 1'b0, 1'b1);
    hold_line(1'b1, 1'b1, CB);
    chk("after_break_count", int'(bus_b.count), 1);
    chk("after_break_data", int'(bus_b.rd_data), 'h3C);
    chk("after_break_frame_err", int'(bus_b.frame_err), 0);
    drain_b();

    // overrun: five back-to-back frames into a depth-4 FIFO
    for (int v = 'h10; v <= 'h14; v++) send_frame(1'b1, 8'(v), 1'b0, 1'b1);
    hold_line(1'b1, 1'b1, CB);
    chk("ovr_full", int'(bus_b.full), 1);
    chk("ovr_flag", int'(bus_b.overrun), 1);
    chk("ovr_count", int'(bus_b.count), 4);
    for (int j = 0; j < 4; j++) begin
      chk("ovr_pop_data", int'(bus_b.rd_data), 'h10 + j);
      pop(1'b1);
    end
    chk("ovr_empty", int'(bus_b.empty), 1);
    clr_b();

    // push into a full FIFO while the head is popped in the same cycle
    for (int j = 0; j < 4; j++) send_frame(1'b1, 8'('h20 + j), 1'b0, 1'b1);
    chk("simul_pre_full", int'(bus_b.full), 1);
    fork
      send_frame(1'b1, 8'h77, 1'b0, 1'b1);
      begin
        repeat (PUSH_EDGE_B - 1) @(negedge clk);
        bus_b.rd_en = 1'b1;
        @(negedge clk);
        bus_b.rd_en = 1'b0;
      end
    join
    hold_line(1'b1, 1'b1, CB);
    chk("simul_count", int'(bus_b.count), 4);
    chk("simul_overrun", int'(bus_b.overrun), 0);
    for (int j = 1; j < 4; j++) begin
      chk("simul_pop_data", int'(bus_b.rd_data), 'h20 + j);
      pop(1'b1);
    end
    chk("simul_last_data", int'(bus_b.rd_data), 'h77);
    pop(1'b1);
    clr_b();

    // reset in the middle of bit 3 of 0x55 flushes state
    send_frame(1'b1, 8'hA5, 1'b0, 1'b1);
    send_frame(1'b1, 8'hA5, 1'b1, 1'b1);
    chk("prerst_count", int'(bus_b.count), 1);
    chk("prerst_parity_err", int'(bus_b.parity_err), 1);
    fork
      send_frame(1'b1, 8'h55, 1'b0, 1'b1);
      begin
        repeat (4 * CB + HB) @(negedge clk);
        nreset_b = 1'b0;
        #1;
        chk_reset_vals(1'b1);
      end
    join
    hold_line(1'b1, 1'b1, 4);
    nreset_b = 1'b1;
    hold_line(1'b1, 1'b1, 6);
    chk_reset_vals(1'b1);
    send_frame(1'b1, 8'h55, 1'b0, 1'b1);
    hold_line(1'b1, 1'b1, CB);
    chk("postrst_count", int'(bus_b.count), 1);
    chk("postrst_data", int'(bus_b.rd_data), 'h55);
    drain_b();
    clr_b();

    // randomized frames against a queue model
    q.delete();
    e_perr = 0; e_ferr = 0; e_ovr = 0;
    for (int it = 0; it < 60; it++) begin
      b = 8'($urandom_range(0, 255));
      f = $urandom_range(0, 9);
      send_frame(1'b1, b, f == 0, f != 1);
      if (f == 1)      e_ferr = 1;
      else if (f == 0) e_perr = 1;
      else if (q.size() < 4) q.push_back(b);
      else             e_ovr = 1;
      hold_line(1'b1, 1'b1, 4 + $urandom_range(0, 12));
      chk("rnd_count", int'(bus_b.count), q.size());
      if (q.size() > 0) chk("rnd_head", int'(bus_b.rd_data), int'(q[0]));
      chk("rnd_parity_err", int'(bus_b.parity_err), e_perr);
      chk("rnd_frame_err", int'(bus_b.frame_err), e_ferr);
      chk("rnd_overrun", int'(bus_b.overrun), e_ovr);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (q.size() > 0) begin
          chk("rnd_pop_data", int'(bus_b.rd_data), int'(q[0]));
          void'(q.pop_front());
        end
        pop(1'b1);
        chk("rnd_pop_count", int'(bus_b.count), q.size());
      end
      if ($urandom_range(0, 3) == 0) begin
        clr_b();
        e_perr = 0; e_ferr = 0; e_ovr = 0;
        chk("rnd_clr", int'({bus_b.frame_err, bus_b.parity_err, bus_b.overrun}), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
